mpc_bank_arbiter: RTL and testbench

Per-bank request arbiter for the multi-port cache. It takes the three channel request streams (`channel_req_t`), keeps only the requests whose address decodes to this bank, and picks one per cycle in round-robin order. The winner is registered into a single-entry output stage as a `bank_req_t` tagged with the one-hot channel ID, ready for the bank pipeline. One instance sits in front of each bank, between the channel ingress and the bank's tag/hit logic.

---
 rtl/mpc_types_pkg.sv | 83 ++++++++
 rtl/mpc_rr_arbiter.sv | 22 ++
 rtl/mpc_bank_arbiter.sv | 89 ++++++++
 tb/tb_mpc_bank_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_types_pkg.sv
// Shared multi-port cache types: geometry config, channel/bank request formats
// and the small helpers used by the per-bank arbiter.
package mpc_types;

  localparam int N_CHANNELS = 3;
  localparam int MPC_ADDR_W = 32;
  localparam int MPC_DATA_W = 32;

  typedef struct packed {
    int unsigned dataBits;
    int unsigned lineWords;
    int unsigned sets;
    int unsigned banks;
  } mpc_user_cfg_t;

  typedef struct packed {
    mpc_user_cfg_t u;
    int unsigned   byteWidth;
    int unsigned   offsetWidth;
    int unsigned   setWidth;
    int unsigned   bankWidth;
  } mpc_cfg_t;

  localparam mpc_user_cfg_t MPC_DEFAULT_USER_CFG =
    '{dataBits: 32, lineWords: 4, sets: 64, banks: 4};

  typedef enum logic [2:0] {
    MPC_OP_LOAD  = 3'd0,
    MPC_OP_STORE = 3'd1,
    MPC_OP_FLUSH = 3'd2,
    MPC_OP_INVAL = 3'd3
  } mpc_op_e;

  typedef enum logic [2:0] {
    CACHE_OP_LOAD  = 3'd0,
    CACHE_OP_STORE = 3'd1
  } cache_op_e;

  typedef struct packed {
    mpc_op_e                 op;
    logic [MPC_ADDR_W-1:0]   addr;
    logic [MPC_DATA_W-1:0]   wdata;
  } channel_req_t;

  typedef struct packed {
    logic [N_CHANNELS-1:0]   channel_1hot_id;
    cache_op_e               op;
    logic [MPC_ADDR_W-1:0]   addr;
    logic [MPC_DATA_W-1:0]   wdata;
  } bank_req_t;

  function automatic mpc_cfg_t mpcBuildConfig(mpc_user_cfg_t u);
    mpc_cfg_t c;
    c.u           = u;
    c.byteWidth   = $clog2(u.dataBits / 8);
    c.offsetWidth = $clog2(u.lineWords);
    c.setWidth    = $clog2(u.sets);
    c.bankWidth   = $clog2(u.banks);
    return c;
  endfunction

  // With bankWidth == 0 the mask is empty, so every address maps to bank 0.
  function automatic logic [MPC_ADDR_W-1:0] bank_of(logic [MPC_ADDR_W-1:0] addr, mpc_cfg_t cfg);
    int unsigned           lsb;
    logic [MPC_ADDR_W-1:0] mask;
    lsb  = cfg.byteWidth + cfg.offsetWidth + cfg.setWidth;
    mask = (MPC_ADDR_W'(1) << cfg.bankWidth) - MPC_ADDR_W'(1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic is_legal_op(mpc_op_e op);
    return (op == MPC_OP_LOAD) || (op == MPC_OP_STORE);
  endfunction

  function automatic cache_op_e to_cache_op(mpc_op_e op);
    case (op)
      MPC_OP_LOAD:  return CACHE_OP_LOAD;
      MPC_OP_STORE: return CACHE_OP_STORE;
      default:      return cache_op_e'(op);
    endcase
  endfunction

endpackage

// File: rtl/mpc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the one-hot
// priority position, wrapping around.
module mpc_rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_gnt;

  // Subtracting prio from the doubled request vector borrows through the
  // non-requesting positions, isolating the first requester at/after prio.
  always_comb begin
    dbl_req = {req, req};
    dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, prio});
    gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  end

endmodule

// File: rtl/mpc_bank_arbiter.sv
// Per-bank request arbiter: filters channel requests by bank, picks one per
// cycle in round-robin order and registers it into a single-entry output stage.
module mpc_bank_arbiter
  import mpc_types::*;
#(
  parameter mpc_cfg_t    CFG     = mpcBuildConfig(MPC_DEFAULT_USER_CFG),
  parameter int unsigned BANK_ID = 0,
  parameter int          N_CH    = N_CHANNELS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_CH-1:0]               ch_req_valid_i,
  input  channel_req_t [N_CH-1:0]       ch_req_i,
  output logic [N_CH-1:0]               ch_req_ready_o,
  output logic                          bank_req_valid_o,
  output bank_req_t                     bank_req_o,
  input  logic                          bank_req_ready_i,
  output logic                          err_illegal_op_o
);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] prio_q, prio_d;
  logic            bank_req_valid_q, bank_req_valid_d;
  bank_req_t       bank_req_q, bank_req_d;
  logic            err_q, err_d;
  logic            can_load;
  logic            accept;
  channel_req_t    win;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
    assign hit[gi] = ch_req_valid_i[gi] &&
                     (bank_of(ch_req_i[gi].addr, CFG) == MPC_ADDR_W'(BANK_ID));
  end

  mpc_rr_arbiter #(.N(N_CH)) u_rr (
    .req  (hit),
    .prio (prio_q),
    .gnt  (gnt)
  );

  assign can_load = !bank_req_valid_q || bank_req_ready_i;
  assign accept   = (|gnt) && can_load;
  // Reset gating keeps the channels from seeing an accept while the stage is held.
  assign ch_req_ready_o = rst_i ? '0 : (gnt & {N_CH{can_load}});

  always_comb begin
    win = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt[c]) win = ch_req_i[c];
    end

    prio_d           = prio_q;
    bank_req_valid_d = bank_req_valid_q;
    bank_req_d       = bank_req_q;
    err_d            = 1'b0;

    if (accept) begin
      prio_d                     = {gnt[N_CH-2:0], gnt[N_CH-1]};
      bank_req_valid_d           = 1'b1;
      bank_req_d.channel_1hot_id = gnt;
      bank_req_d.op              = to_cache_op(win.op);
      bank_req_d.addr            = win.addr;
      bank_req_d.wdata           = win.wdata;
      err_d                      = !is_legal_op(win.op);
    end else if (bank_req_ready_i) begin
      bank_req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q           <= N_CH'(1);
      bank_req_valid_q <= 1'b0;
      bank_req_q       <= '0;
      err_q            <= 1'b0;
    end else begin
      prio_q           <= prio_d;
      bank_req_valid_q <= bank_req_valid_d;
      bank_req_q       <= bank_req_d;
      err_q            <= err_d;
    end
  end

  assign bank_req_valid_o = bank_req_valid_q;
  assign bank_req_o       = bank_req_q;
  assign err_illegal_op_o = err_q;

endmodule

// File: tb/tb_mpc_bank_arbiter.sv
// Self-checking bench for mpc_bank_arbiter (BANK_ID = 2, default geometry:
// bank field at addr[11:10]) using a cycle model and an output scoreboard.
module tb_mpc_bank_arbiter;
  import mpc_types::*;

  logic                  clk;
  logic                  rst;
  logic [2:0]            ch_valid;
  channel_req_t [2:0]    ch_req;
  logic [2:0]            ch_ready;
  logic                  bank_valid;
  bank_req_t             bank_req;
  logic                  bank_rdy;
  logic                  err;

  typedef struct packed {
    bank_req_t req;
    logic      err;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failed    = 0;
  int   m_pidx;
  bit   m_valid;

  mpc_bank_arbiter #(.BANK_ID(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ch_req_valid_i   (ch_valid),
    .ch_req_i         (ch_req),
    .ch_req_ready_o   (ch_ready),
    .bank_req_valid_o (bank_valid),
    .bank_req_o       (bank_req),
    .bank_req_ready_i (bank_rdy),
    .err_illegal_op_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_addr(input logic [1:0] b);
    logic [31:0] a;
    a = $urandom;
    a[11:10] = b;
    return a;
  endfunction

  function automatic channel_req_t mk_req(input mpc_op_e op, input logic [1:0] b);
    channel_req_t r;
    r.op    = op;
    r.addr  = mk_addr(b);
    r.wdata = $urandom;
    return r;
  endfunction

  // Model one clock: sample ready, predict grant, push expected output, advance.
  task automatic tick(output logic [2:0] exp_rdy, output logic [2:0] got_rdy, output bit loaded);
    logic [2:0] hit;
    int         g;
    exp_t       e;
    #1;
    got_rdy = ch_ready;
    for (int c = 0; c < 3; c++) hit[c] = ch_valid[c] && (ch_req[c].addr[11:10] == 2'd2);
    g = -1;
    for (int o = 0; o < 3; o++) begin
      int idx;
      idx = (m_pidx + o) % 3;
      if (g < 0 && hit[idx]) g = idx;
    end
    exp_rdy = 3'b000;
    loaded  = 1'b0;
    if (g >= 0 && (!m_valid || bank_rdy)) begin
      exp_rdy[g]           = 1'b1;
      e.req.channel_1hot_id = 3'b001 << g;
      e.req.op             = cache_op_e'(ch_req[g].op);
      e.req.addr           = ch_req[g].addr;
      e.req.wdata          = ch_req[g].wdata;
      e.err                = (ch_req[g].op > 3'd1);
      sb.push_back(e);
      m_pidx  = (g + 1) % 3;
      m_valid = 1'b1;
      loaded  = 1'b1;
    end else if (bank_rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (loaded) $display("[TB] load ch=%b op=%0d addr=%h", bank_req.channel_1hot_id, bank_req.op, bank_req.addr);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pidx  = 0;
    m_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ch_valid = 3'b000;
    bank_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bank_rdy = 1'b1;
    ch_valid = 3'b111;
    for (int c = 0; c < 3; c++) ch_req[c] = mk_req(MPC_OP_LOAD, 2'd2);
    #3;
    tests_run++;
    if (ch_ready !== 3'b000 || bank_valid !== 1'b0 || bank_req !== '0 || err !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: rdy=%b valid=%b req=%h err=%b, required 000/0/0/0", ch_ready, bank_valid, bank_req, err);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (ch_ready !== 3'b000 || bank_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_hold: rdy=%b valid=%b, required 000/0", ch_ready, bank_valid);
    end
    ch_valid = 3'b000;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    channel_req_t r;
    do_reset();
    r = mk_req(MPC_OP_LOAD, 2'd2);
    ch_req[1] = r;
    ch_valid  = 3'b010;
    tick(er, gr, ld);
    ch_valid = 3'b000;
    tests_run++;
    if (gr !== 3'b010) begin failed++; $display("FAIL single_ready: got %b, required 010", gr); end
    tests_run++;
    if (bank_valid !== 1'b1 || bank_req.channel_1hot_id !== 3'b010 || bank_req.op !== CACHE_OP_LOAD || bank_req.addr !== r.addr) begin
      failed++;
      $display("FAIL single_out: valid=%b id=%b op=%0d addr=%h, required 1/010/0/%h", bank_valid, bank_req.channel_1hot_id, bank_req.op, bank_req.addr, r.addr);
    end
    if (ld) begin
      e = sb.pop_front();
      tests_run++;
      if (bank_req !== e.req || err !== e.err) begin failed++; $display("FAIL single_sb: got %h/%b, required %h/%b", bank_req, err, e.req, e.err); end
    end
    tick(er, gr, ld);
    tests_run++;
    if (bank_valid !== m_valid || gr !== er) begin failed++; $display("FAIL single_drain: valid=%b rdy=%b, required %b/%b", bank_valid, gr, m_valid, er); end
  endtask

  task automatic test_contention();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    logic [2:0] order [6];
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    ch_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < 3; c++) if (n == 0 || er[c]) ch_req[c] = mk_req(mpc_op_e'($urandom_range(0, 1)), 2'd2);
      tick(er, gr, ld);
      tests_run++;
      if (gr !== order[n] || gr !== er) begin failed++; $display("FAIL contention_grant%0d: got %b, required %b", n, gr, order[n]); end
      tests_run++;
      if (bank_valid !== m_valid) begin failed++; $display("FAIL contention_valid%0d: got %b, required %b", n, bank_valid, m_valid); end
      if (ld) begin
        e = sb.pop_front();
        tests_run++;
        if (bank_req !== e.req || err !== e.err) begin failed++; $display("FAIL contention_out%0d: got %h/%b, required %h/%b", n, bank_req, err, e.req, e.err); end
      end
    end
    ch_valid = 3'b000;
  endtask

  task automatic test_backpressure();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    bank_req_t  hold;
    do_reset();
    ch_req[0] = mk_req(MPC_OP_LOAD, 2'd2);
    ch_req[2] = mk_req(MPC_OP_STORE, 2'd2);
    hold = '{channel_1hot_id: 3'b001, op: CACHE_OP_LOAD, addr: ch_req[0].addr, wdata: ch_req[0].wdata};
    ch_valid = 3'b101;
    bank_rdy = 1'b0;
    tick(er, gr, ld);
    ch_valid[0] = 1'b0;
    tests_run++;
    if (gr !== 3'b001) begin failed++; $display("FAIL bp_first: got %b, required 001", gr); end
    if (ld) void'(sb.pop_front());
    for (int n = 0; n < 4; n++) begin
      tick(er, gr, ld);
      tests_run++;
      if (gr !== 3'b000 || gr !== er) begin failed++; $display("FAIL bp_ready%0d: got %b, required 000", n, gr); end
      tests_run++;
      if (bank_valid !== 1'b1 || bank_req !== hold) begin failed++; $display("FAIL bp_hold%0d: got %b/%h, required 1/%h", n, bank_valid, bank_req, hold); end
    end
    bank_rdy = 1'b1;
    tick(er, gr, ld);
    ch_valid = 3'b000;
    tests_run++;
    if (gr !== 3'b100) begin failed++; $display("FAIL bp_release: got %b, required 100", gr); end
    if (ld) begin
      e = sb.pop_front();
      tests_run++;
      if (bank_req !== e.req || bank_valid !== 1'b1) begin failed++; $display("FAIL bp_out: got %h, required %h", bank_req, e.req); end
    end
    tick(er, gr, ld);
    tests_run++;
    if (bank_valid !== 1'b0) begin failed++; $display("FAIL bp_drain: got %b, required 0", bank_valid); end
  endtask

  task automatic test_filter();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    do_reset();
    ch_req[0] = mk_req(MPC_OP_LOAD, 2'd1);
    ch_valid  = 3'b011;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) ch_valid[2] = 1'b1;
      if (n == 0 || er[1]) ch_req[1] = mk_req(MPC_OP_STORE, 2'd2);
      if (n == 4 || er[2]) ch_req[2] = mk_req(MPC_OP_LOAD, 2'd2);
      tick(er, gr, ld);
      tests_run++;
      if (gr[0] !== 1'b0 || gr !== er) begin failed++; $display("FAIL filter_ready%0d: got %b, required %b", n, gr, er); end
      if (ld) begin
        e = sb.pop_front();
        tests_run++;
        if (bank_req !== e.req || err !== e.err) begin failed++; $display("FAIL filter_out%0d: got %h, required %h", n, bank_req, e.req); end
      end
    end
    ch_valid = 3'b000;
  endtask

  task automatic test_illegal_op();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    do_reset();
    ch_req[2] = mk_req(mpc_op_e'(3'd5), 2'd2);
    ch_valid  = 3'b100;
    tick(er, gr, ld);
    ch_valid = 3'b000;
    tests_run++;
    if (gr !== 3'b100 || bank_req.op !== cache_op_e'(3'd5) || err !== 1'b1) begin
      failed++;
      $display("FAIL illegal_load: rdy=%b op=%0d err=%b, required 100/5/1", gr, bank_req.op, err);
    end
    if (ld) begin
      e = sb.pop_front();
      tests_run++;
      if (bank_req !== e.req || err !== e.err) begin failed++; $display("FAIL illegal_sb: got %h/%b, required %h/%b", bank_req, err, e.req, e.err); end
    end
    tick(er, gr, ld);
    tests_run++;
    if (err !== 1'b0) begin failed++; $display("FAIL illegal_pulse: err=%b, required 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] er, gr;
    bit         ld;
    exp_t       e;
    do_reset();
    er = 3'b000;
    for (int n = 0; n < 200; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (!ch_valid[c] || er[c]) begin
          ch_valid[c] = ($urandom_range(0, 3) != 0);
          ch_req[c]   = mk_req(($urandom_range(0, 7) == 0) ? mpc_op_e'(3'd5) : mpc_op_e'($urandom_range(0, 1)),
                               2'($urandom_range(1, 2)));
        end
      end
      bank_rdy = ($urandom_range(0, 3) != 0);
      tick(er, gr, ld);
      tests_run++;
      if (gr !== er) begin failed++; $display("FAIL b2b_ready%0d: got %b, required %b", n, gr, er); end
      tests_run++;
      if (bank_valid !== m_valid) begin failed++; $display("FAIL b2b_valid%0d: got %b, required %b", n, bank_valid, m_valid); end
      if (ld) begin
        e = sb.pop_front();
        tests_run++;
        if (bank_req !== e.req || err !== e.err) begin failed++; $display("FAIL b2b_out%0d: got %h/%b, required %h/%b", n, bank_req, err, e.req, e.err); end
      end else begin
        tests_run++;
        if (err !== 1'b0) begin failed++; $display("FAIL b2b_err%0d: got %b, required 0", n, err); end
      end
    end
    ch_valid = 3'b000;
    bank_rdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [2:0] er, gr;
    bit         ld;
    do_reset();
    ch_req[1] = mk_req(MPC_OP_LOAD, 2'd2);
    ch_valid  = 3'b010;
    bank_rdy  = 1'b0;
    tick(er, gr, ld);
    ch_valid = 3'b000;
    tests_run++;
    if (bank_valid !== 1'b1) begin failed++; $display("FAIL mid_setup: valid=%b, required 1", bank_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bank_valid !== 1'b0 || bank_req !== '0 || ch_ready !== 3'b000) begin
      failed++;
      $display("FAIL mid_reset: valid=%b req=%h rdy=%b, required 0/0/000", bank_valid, bank_req, ch_ready);
    end
    model_reset();
    #3;
    rst      = 1'b0;
    bank_rdy = 1'b1;
    ch_valid = 3'b111;
    for (int c = 0; c < 3; c++) ch_req[c] = mk_req(MPC_OP_STORE, 2'd2);
    tick(er, gr, ld);
    ch_valid = 3'b000;
    tests_run++;
    if (gr !== 3'b001 || bank_req.channel_1hot_id !== 3'b001) begin
      failed++;
      $display("FAIL mid_first_grant: rdy=%b id=%b, required 001/001", gr, bank_req.channel_1hot_id);
    end
  endtask

  initial begin
    ch_valid = 3'b000;
    ch_req   = '0;
    bank_rdy = 1'b1;
    rst      = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_filter();
    test_illegal_op();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
